// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants.
// Used by the receiver and the 16x sample-clock divider.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int UART_OVERSAMPLE = 16;
  localparam int UART_DATA_BITS  = 8;
  localparam int SYS_CLK_HZ      = 50_000_000;
  localparam int UART_BAUD       = 9600;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizers for rxd/sclk, sclk rise -> tick.
// Ports: clk50, rst_n, sclk, rxd in; rxd_s (synced line), tick out.
module uart_rx_sync (
  input  logic clk50,
  input  logic rst_n,
  input  logic sclk,
  input  logic rxd,
  output logic rxd_s,
  output logic tick
);

  logic [1:0] rxd_q, rxd_d;
  logic [2:0] sclk_q, sclk_d;

  always_comb begin
    rxd_d  = {rxd_q[0], rxd};
    sclk_d = {sclk_q[1:0], sclk};
  end

  // line idles high, so the rxd chain resets to 1
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      rxd_q  <= 2'b11;
      sclk_q <= 3'b000;
    end else begin
      rxd_q  <= rxd_d;
      sclk_q <= sclk_d;
    end
  end

  assign rxd_s = rxd_q[1];
  // third sclk flop is the edge-detect history
  assign tick  = sclk_q[1] & ~sclk_q[2];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8N1 (8E1 with UART_RX_PARITY_EN).
// Ports: clk50, rst_n, sclk, rxd in; rx_data, rx_valid, rx_frame_err,
// rx_parity_err, rx_busy out.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE,
  parameter int DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk50,
  input  logic                 rst_n,
  input  logic                 sclk,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rxd_s;
  logic tick;

  uart_rx_sync u_sync (
    .clk50 (clk50),
    .rst_n (rst_n),
    .sclk  (sclk),
    .rxd   (rxd),
    .rxd_s (rxd_s),
    .tick  (tick)
  );

  uart_state_e          state_q, state_d;
  logic [SW-1:0]        scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 wait_hi_q, wait_hi_d;
  logic                 par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic perr_q, perr_d;
  // even parity: data bits plus parity bit xor to 0
  assign par_bad = ^{sh_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bcnt_d    = bcnt_q;
    sh_d      = sh_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    wait_hi_d = wait_hi_q;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    perr_d    = 1'b0;
`endif
    if (tick) begin
      scnt_d = scnt_q + 1'b1;
      unique case (state_q)
        IDLE: begin
          scnt_d = '0;
          bcnt_d = '0;
          // after a framing error, hold off until the line goes high
          if (wait_hi_q) begin
            if (rxd_s) wait_hi_d = 1'b0;
          end else if (!rxd_s) begin
            state_d = START;
          end
        end
        START: begin
          if (scnt_q == S_MID) begin
            scnt_d  = '0;
            state_d = rxd_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (scnt_q == S_END) begin
            sh_d   = {rxd_s, sh_q[DATA_BITS-1:1]};
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == B_LAST) begin
              bcnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (scnt_q == S_END) begin
            par_d   = rxd_s;
            state_d = STOP;
          end
        end
`endif
        STOP: begin
          if (scnt_q == S_END) begin
            state_d = IDLE;
            if (!rxd_s) begin
              ferr_d    = 1'b1;
              wait_hi_d = 1'b1;
            end else if (!par_bad) begin
              data_d  = sh_q;
              valid_d = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_d = par_bad;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      wait_hi_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      wait_hi_q <= wait_hi_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
  assign rx_parity_err = perr_q;
`else
  assign rx_parity_err = 1'b0;
`endif

  assign rx_data      = data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;
  assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed-vector bench for uart_rx.
// Drives sclk from a small divider and serial frames on rxd.
module tb_uart_rx;

  localparam int OS  = 16;
  localparam int DIV = 6;
  localparam int BIT = OS * DIV;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk  = 1'b0;
  logic       rxd   = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  int n_ferr  = 0;
  int n_perr  = 0;
  int dcnt    = 0;
  logic [7:0] cap[$];

  uart_rx dut (
    .clk50        (clk50),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .rxd          (rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_busy      (rx_busy)
  );

  always #10 clk50 = ~clk50;

  always @(posedge clk50) begin
    dcnt <= (dcnt == DIV - 1) ? 0 : dcnt + 1;
    sclk <= (dcnt < DIV / 2);
  end

  always @(negedge clk50) begin
    if (rx_valid) begin
      n_valid++;
      cap.push_back(rx_data);
    end
    if (rx_frame_err) n_ferr++;
    if (rx_parity_err) n_perr++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bit_out(input logic b);
    rxd = b;
    repeat (BIT) @(negedge clk50);
  endtask

  task automatic send(input logic [7:0] d, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_out(^d);
`endif
    bit_out(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_p(input logic [7:0] d, input logic par);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(d[i]);
    bit_out(par);
    bit_out(1'b1);
  endtask
`endif

  initial begin
    logic [7:0] c3;
    c3 = 8'hC3;

    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (4) @(negedge clk50);
    chk("rst_data", rx_data, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_ferr", rx_frame_err, 0);
    chk("rst_perr", rx_parity_err, 0);
    chk("rst_busy", rx_busy, 0);
    rst_n = 1'b1;
    bit_out(1'b1);
    bit_out(1'b1);

    send(8'h55, 1'b1);
    bit_out(1'b1);
    chk("b55_nvalid", n_valid, 1);
    chk("b55_data", cap[0], 8'h55);
    chk("b55_nferr", n_ferr, 0);
    chk("b55_busy", rx_busy, 0);

    send(8'hA5, 1'b1);
    send(8'h3C, 1'b1);
    bit_out(1'b1);
    chk("b2b_nvalid", n_valid, 3);
    chk("b2b_d0", cap[1], 8'hA5);
    chk("b2b_d1", cap[2], 8'h3C);

    rxd = 1'b0;
    repeat (3 * DIV) @(negedge clk50);
    chk("glitch_busy_hi", rx_busy, 1);
    rxd = 1'b1;
    repeat (2 * BIT) @(negedge clk50);
    chk("glitch_busy_lo", rx_busy, 0);
    chk("glitch_nvalid", n_valid, 3);
    chk("glitch_nferr", n_ferr, 0);

    send(8'h7E, 1'b0);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b1);
    chk("ferr_nferr", n_ferr, 1);
    chk("ferr_nvalid", n_valid, 3);
    chk("ferr_data", rx_data, 8'h3C);
    chk("ferr_busy", rx_busy, 0);

    bit_out(1'b0);
    for (int i = 0; i < 4; i++) bit_out(c3[i]);
    rxd = c3[4];
    repeat (BIT / 2) @(negedge clk50);
    chk("abort_busy_mid", rx_busy, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk50);
    chk("abort_busy_rst", rx_busy, 0);
    chk("abort_data_rst", rx_data, 0);
    rst_n = 1'b1;
    rxd   = 1'b1;
    repeat (2 * BIT) @(negedge clk50);
    chk("abort_nvalid", n_valid, 3);
    chk("abort_nferr", n_ferr, 1);
    send(8'h12, 1'b1);
    bit_out(1'b1);
    chk("after_nvalid", n_valid, 4);
    chk("after_cap", cap[3], 8'h12);
    chk("after_data", rx_data, 8'h12);

`ifdef UART_RX_PARITY_EN
    send_p(8'h01, 1'b0);
    bit_out(1'b1);
    chk("par_bad_nperr", n_perr, 1);
    chk("par_bad_nvalid", n_valid, 4);
    chk("par_bad_data", rx_data, 8'h12);
    send_p(8'h01, 1'b1);
    bit_out(1'b1);
    chk("par_ok_nvalid", n_valid, 5);
    chk("par_ok_data", cap[4], 8'h01);
    chk("par_ok_nperr", n_perr, 1);
`else
    chk("nopar_nperr", n_perr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
